// File: rtl/lvds_panel_sequencer.sv
// rtl/lvds_panel_sequencer.sv - LVDS panel power sequencer (VDD -> LVDS -> backlight), optional LVDS_BL_VSYNC_ALIGN_EN
module lvds_panel_sequencer #(
    parameter int CNT_W      = 16,
    parameter int T_VDD_LVDS = 16,
    parameter int T_LVDS_BL  = 16,
    parameter int T_BL_LVDS  = 16,
    parameter int T_LVDS_VDD = 16,
    parameter int T_OFF_MIN  = 16
) (
    input  logic       DotClock,
    input  logic       rst_n,
    input  logic       panel_on,
    input  logic       VSync,
    output logic       vdd_en,
    output logic       lvds_en,
    output logic       bl_en,
    output logic       ready,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_PU_VDD  = 3'd1,
        S_PU_LVDS = 3'd2,
        S_ON      = 3'd3,
        S_PD_BL   = 3'd4,
        S_PD_LVDS = 3'd5,
        S_PD_VDD  = 3'd6,
        S_BAD     = 3'd7
    } state_t;

    // A zero delay is treated as a one-cycle delay.
    localparam logic [CNT_W-1:0] LD_VDD_LVDS = (T_VDD_LVDS == 0) ? CNT_W'(1) : CNT_W'(T_VDD_LVDS);
    localparam logic [CNT_W-1:0] LD_LVDS_BL  = (T_LVDS_BL  == 0) ? CNT_W'(1) : CNT_W'(T_LVDS_BL);
    localparam logic [CNT_W-1:0] LD_BL_LVDS  = (T_BL_LVDS  == 0) ? CNT_W'(1) : CNT_W'(T_BL_LVDS);
    localparam logic [CNT_W-1:0] LD_LVDS_VDD = (T_LVDS_VDD == 0) ? CNT_W'(1) : CNT_W'(T_LVDS_VDD);
    localparam logic [CNT_W-1:0] LD_OFF_MIN  = (T_OFF_MIN  == 0) ? CNT_W'(1) : CNT_W'(T_OFF_MIN);

    state_t           cur_st;
    state_t           nxt_st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             expired;
    logic             lvds_go;

    // The counter parks at 1 once expired, so "expired" stays true while waiting.
    assign expired = (cnt == CNT_W'(1));

`ifdef LVDS_BL_VSYNC_ALIGN_EN
    logic vsync_q;

    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= VSync;
        end
    end

    assign lvds_go = expired & VSync & ~vsync_q;
`else
    logic unused_vsync;
    assign unused_vsync = VSync;
    assign lvds_go      = expired;
`endif

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_OFF:     if (panel_on) nxt_st = S_PU_VDD;
            S_PU_VDD:  if (!panel_on) nxt_st = S_PD_VDD;
                       else if (expired) nxt_st = S_PU_LVDS;
            S_PU_LVDS: if (!panel_on) nxt_st = S_PD_LVDS;
                       else if (lvds_go) nxt_st = S_ON;
            S_ON:      if (!panel_on) nxt_st = S_PD_BL;
            S_PD_BL:   if (expired) nxt_st = S_PD_LVDS;
            S_PD_LVDS: if (expired) nxt_st = S_PD_VDD;
            S_PD_VDD:  if (expired) nxt_st = S_OFF;
            default:   nxt_st = S_PD_VDD;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (nxt_st != cur_st) begin
            case (nxt_st)
                S_PU_VDD:  cnt_nxt = LD_VDD_LVDS;
                S_PU_LVDS: cnt_nxt = LD_LVDS_BL;
                S_PD_BL:   cnt_nxt = LD_BL_LVDS;
                S_PD_LVDS: cnt_nxt = LD_LVDS_VDD;
                S_PD_VDD:  cnt_nxt = LD_OFF_MIN;
                default:   cnt_nxt = '0;
            endcase
        end else if (cnt > CNT_W'(1)) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Outputs are registered from the next-state decode so they always match the state register.
    always_ff @(posedge DotClock or negedge rst_n) begin
        if (!rst_n) begin
            cur_st  <= S_OFF;
            cnt     <= '0;
            vdd_en  <= 1'b0;
            lvds_en <= 1'b0;
            bl_en   <= 1'b0;
            ready   <= 1'b0;
        end else begin
            cur_st  <= nxt_st;
            cnt     <= cnt_nxt;
            vdd_en  <= (nxt_st == S_PU_VDD) || (nxt_st == S_PU_LVDS) || (nxt_st == S_ON) ||
                       (nxt_st == S_PD_BL)  || (nxt_st == S_PD_LVDS);
            lvds_en <= (nxt_st == S_PU_LVDS) || (nxt_st == S_ON) || (nxt_st == S_PD_BL);
            bl_en   <= (nxt_st == S_ON);
            ready   <= (nxt_st == S_ON);
        end
    end

    assign state = cur_st;

endmodule
